cache_mem_arbiter: RTL and testbench

- Shares one external memory port between the instruction cache (line refill, read-only) and the data cache (line refill or line write-back).
- Sits between the two caches and the memory/bus interface, below the pipeline controller, whose instruction and data stalls depend on the caches' ready signals.
- Performs one fixed-length burst per grant.
- Uses 2-way round-robin arbitration when both caches request in the same cycle.

---
 rtl/cache_mem_arbiter_pkg.sv | 18 +
 rtl/cache_mem_arbiter_arb.sv | 13 +
 rtl/cache_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache/memory arbiter.
// State encodings and grant codes.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/cache_mem_arbiter_arb.sv
// Two-way round-robin arbiter.
// Bit 0 is the I-cache and bit 1 is the D-cache; last_owner 1 means D.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic       en,
    output logic [1:0] gnt
);

    assign gnt[0] = en & req[0] & (~req[1] | last_owner);
    assign gnt[1] = en & req[1] & (~req[0] | ~last_owner);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between the I-cache and the D-cache.
// One fixed-length line burst per grant.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);

    state_t            state;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ADDR_W-1:0] base;
    logic              we;
    logic              last_owner;
    logic [1:0]        gnt;

    logic burst;
    logic own_i;
    logic own_d;

    rr_arb2 u_arb (
        .req        ({d_req, i_req}),
        .last_owner (last_owner),
        .en         (state == IDLE),
        .gnt        (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= GNT_NONE;
            beat_cnt   <= '0;
            base       <= '0;
            we         <= 1'b0;
            last_owner <= OWN_D;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt[0]) begin
                        grant      <= GNT_I;
                        base       <= i_addr & LINE_MASK;
                        we         <= 1'b0;
                        beat_cnt   <= '0;
                        last_owner <= OWN_I;
                        state      <= BURST;
                    end else if (gnt[1]) begin
                        grant      <= GNT_D;
                        base       <= d_addr & LINE_MASK;
                        we         <= d_we;
                        beat_cnt   <= '0;
                        last_owner <= OWN_D;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (mem_ack) begin
                        if (beat_cnt == LAST) begin
                            beat_cnt <= '0;
                            state    <= DONE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    grant <= GNT_NONE;
                    state <= IDLE;
                end
                default: begin
                    grant <= GNT_NONE;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign burst = (state == BURST);
    assign own_i = (grant == GNT_I);
    assign own_d = (grant == GNT_D);

    // Outputs are gated by state so everything reads 0 outside a burst.
    assign mem_req   = burst;
    assign mem_we    = burst & we;
    assign mem_addr  = burst ? base + ADDR_W'({beat_cnt, 2'b00}) : '0;
    assign mem_wdata = burst ? d_wdata : '0;

    assign i_rvalid = mem_ack & ~we & burst & own_i;
    assign d_rvalid = mem_ack & ~we & burst & own_d;
    assign d_wready = mem_ack & we & burst & own_d;

    assign i_rdata = (burst & own_i) ? mem_rdata : '0;
    assign d_rdata = (burst & own_d) ? mem_rdata : '0;

    assign i_done = (state == DONE) & own_i;
    assign d_done = (state == DONE) & own_d;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed steps plus random
// request mixes checked against a transaction-level model.
module tb_cache_mem_arbiter;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        i_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_wready;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata;
    logic [1:0]  grant;

    int total = 0;
    int bad = 0;
    bit last_d = 1'b1;

    cache_mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .LINE_WORDS (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_rvalid  (i_rvalid),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wready  (d_wready),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    assign mem_rdata = memf(mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Entered in the IDLE cycle in which the request is first seen.
    task automatic burst(input logic [1:0] g, input logic [31:0] addr,
                         input logic we, input int mode, input bit hold,
                         input int raise_at, input bit drop_mid);
        logic [31:0] base;
        logic [31:0] ea;
        logic        ack;
        bit          own_d;
        int          k;
        int          nrv;
        int          nwr;
        own_d = (g == 2'b10);
        base = addr & ~32'(LW * 4 - 1);
        k = 0;
        nrv = 0;
        nwr = 0;
        #1;
        chk("idle_req", {31'b0, mem_req}, 0);
        chk("idle_gnt", {30'b0, grant}, 0);
        chk("idle_rv", {29'b0, i_rvalid, d_rvalid, d_wready}, 0);
        for (int c = 0; c < 100 && k < LW; c++) begin
            cyc();
            if (mode == 0) ack = 1'b1;
            else if (mode == 1) ack = c[0];
            else ack = ($urandom_range(0, 9) < 6);
            mem_ack = ack;
            d_wdata = $urandom;
            if (c == raise_at) d_req = 1'b1;
            if (drop_mid && c == 1) begin
                if (own_d) d_req = 1'b0;
                else i_req = 1'b0;
            end
            #1;
            ea = base + 32'(4 * k);
            chk("gnt", {30'b0, grant}, {30'b0, g});
            chk("mreq", {31'b0, mem_req}, 1);
            chk("mwe", {31'b0, mem_we}, {31'b0, we});
            chk("maddr", mem_addr, ea);
            chk("mwdata", mem_wdata, d_wdata);
            chk("own_rv", {31'b0, own_d ? d_rvalid : i_rvalid},
                {31'b0, ack & ~we});
            chk("oth_rv", {31'b0, own_d ? i_rvalid : d_rvalid}, 0);
            chk("wrdy", {31'b0, d_wready}, {31'b0, ack & we});
            chk("dones", {30'b0, i_done, d_done}, 0);
            if (ack & ~we) begin
                chk("rdata", own_d ? d_rdata : i_rdata, memf(ea));
                nrv++;
            end
            if (ack & we) nwr++;
            if (ack) k++;
        end
        chk("beats", k, LW);
        cyc();
        mem_ack = 1'b1;
        if (!hold) begin
            if (own_d) d_req = 1'b0;
            else i_req = 1'b0;
        end
        #1;
        chk("done_own", {31'b0, own_d ? d_done : i_done}, 1);
        chk("done_oth", {31'b0, own_d ? i_done : d_done}, 0);
        chk("done_mreq", {31'b0, mem_req}, 0);
        chk("done_rv", {29'b0, i_rvalid, d_rvalid, d_wready}, 0);
        chk("n_rvalid", nrv, we ? 0 : LW);
        chk("n_wready", nwr, we ? LW : 0);
        last_d = own_d;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk("rst_gnt", {30'b0, grant}, 0);
        chk("rst_mreq", {31'b0, mem_req}, 0);
        cyc();
        rst = 1'b0;
        last_d = 1'b1;
    endtask

    initial begin
        logic [31:0] ia;
        logic [31:0] da;
        logic        dwe;
        logic [1:0]  sel;
        logic [1:0]  first;
        int          mode;
        bit          drop;

        #1;
        chk("rst0_mreq", {31'b0, mem_req}, 0);
        chk("rst0_gnt", {30'b0, grant}, 0);
        chk("rst0_addr", mem_addr, 0);
        chk("rst0_out", {28'b0, i_rvalid, d_rvalid, i_done, d_done}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // I-cache refill, zero-wait memory
        i_addr = 32'h0000_1234;
        i_req = 1'b1;
        mem_ack = 1'b1;
        burst(2'b01, 32'h0000_1234, 1'b0, 0, 1'b0, -1, 1'b0);

        // acks while idle do nothing
        repeat (3) begin
            cyc();
            mem_ack = 1'b1;
            #1;
            chk("idleack_rv", {29'b0, i_rvalid, d_rvalid, d_wready}, 0);
            chk("idleack_mreq", {31'b0, mem_req}, 0);
        end

        // D-cache write-back, ack on alternate cycles
        cyc();
        d_addr = 32'h0000_0080;
        d_we = 1'b1;
        d_req = 1'b1;
        burst(2'b10, 32'h0000_0080, 1'b1, 1, 1'b0, -1, 1'b0);

        // simultaneous requests, held: I, D, I, D
        do_reset();
        cyc();
        i_addr = 32'h0000_2000;
        d_addr = 32'h0000_3004;
        d_we = 1'b0;
        i_req = 1'b1;
        d_req = 1'b1;
        burst(2'b01, 32'h0000_2000, 1'b0, 0, 1'b1, -1, 1'b0);
        cyc();
        burst(2'b10, 32'h0000_3004, 1'b0, 0, 1'b1, -1, 1'b0);
        cyc();
        burst(2'b01, 32'h0000_2000, 1'b0, 0, 1'b0, -1, 1'b0);
        cyc();
        burst(2'b10, 32'h0000_3004, 1'b0, 0, 1'b0, -1, 1'b0);

        // D request arrives mid I burst
        cyc();
        i_addr = 32'h0000_4444;
        i_req = 1'b1;
        d_addr = 32'h0000_5550;
        d_we = 1'b1;
        burst(2'b01, 32'h0000_4444, 1'b0, 2, 1'b0, 2, 1'b0);
        cyc();
        burst(2'b10, 32'h0000_5550, 1'b1, 0, 1'b0, -1, 1'b0);

        // reset after two beats of a D refill
        cyc();
        d_addr = 32'h0000_0080;
        d_we = 1'b0;
        d_req = 1'b1;
        mem_ack = 1'b1;
        d_wdata = 32'hDEAD_BEEF;
        for (int b = 0; b < 3; b++) begin
            cyc();
            #1;
            chk("pre_rst_addr", mem_addr, 32'h80 + 32'(4 * b));
        end
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_mreq", {31'b0, mem_req}, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_wdata", mem_wdata, 0);
        chk("midrst_rdata", d_rdata, 0);
        chk("midrst_flags", {27'b0, mem_we, d_rvalid, d_wready,
                             d_done, i_done}, 0);
        chk("midrst_gnt", {30'b0, grant}, 0);
        repeat (2) begin
            cyc();
            chk("midrst_nodone", {31'b0, d_done}, 0);
        end
        rst = 1'b0;
        last_d = 1'b1;
        burst(2'b10, 32'h0000_0080, 1'b0, 0, 1'b0, -1, 1'b0);

        // random request mixes against the round-robin model
        for (int it = 0; it < 25; it++) begin
            cyc();
            sel = 2'($urandom_range(1, 3));
            ia = $urandom;
            da = $urandom;
            dwe = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 2);
            drop = 1'($urandom_range(0, 1));
            i_addr = ia;
            d_addr = da;
            d_we = dwe;
            i_req = sel[0];
            d_req = sel[1];
            if (sel == 2'b11) first = last_d ? 2'b01 : 2'b10;
            else first = sel;
            if (first == 2'b01)
                burst(2'b01, ia, 1'b0, mode, 1'b0, -1, drop);
            else
                burst(2'b10, da, dwe, mode, 1'b0, -1, drop);
            if (sel == 2'b11) begin
                cyc();
                if (first == 2'b01)
                    burst(2'b10, da, dwe, mode, 1'b0, -1, 1'b0);
                else
                    burst(2'b01, ia, 1'b0, mode, 1'b0, -1, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
